// File: rtl/game_mode_ctrl_if.sv
// Status and event bundle between the screen-mode sequencer and the display/object logic.
// The sequencer is the slave: it takes the raw buttons and game events and returns mode/lives/wave.
interface game_mode_ctrl_if;
   logic       button_display;
   logic       button_center;
   logic       frame_tick;
   logic       player_hit;
   logic       aliens_cleared;
   logic [1:0] mode;
   logic       objects_frozen;
   logic       game_start;
   logic [1:0] lives;
   logic [3:0] wave;

   modport master (
      output button_display, button_center, frame_tick, player_hit, aliens_cleared,
      input  mode, objects_frozen, game_start, lives, wave
   );

   modport slave (
      input  button_display, button_center, frame_tick, player_hit, aliens_cleared,
      output mode, objects_frozen, game_start, lives, wave
   );
endinterface

// File: rtl/game_mode_ctrl.sv
// Screen-mode sequencer: debounced buttons step BLACK/START/GAME/GAME_OVER and track lives and wave.
// A steady button edge reaches the FSM ~DB_CYCLES+2 cycles later; event effects show next cycle; no backpressure.
module game_mode_ctrl #(
   parameter int DB_CYCLES   = 500000,
   parameter int DB_WIDTH    = 20,
   parameter int START_LIVES = 3,
   parameter int OVER_FRAMES = 180
) (
   input  logic             clk,
   input  logic             rst,
   game_mode_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_BLACK = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_GAME  = 2'd2;
   localparam logic [1:0] ST_OVER  = 2'd3;

   localparam int                 FC_W       = $clog2(OVER_FRAMES + 1);
   localparam logic [DB_WIDTH-1:0] DB_LAST    = DB_WIDTH'(DB_CYCLES - 1);
   localparam logic [DB_WIDTH-1:0] DB_ONE     = DB_WIDTH'(1);
   localparam logic [FC_W-1:0]     FC_LAST    = FC_W'(OVER_FRAMES - 1);
   localparam logic [FC_W-1:0]     FC_ONE     = FC_W'(1);
   localparam logic [1:0]          LIVES_INIT = 2'(START_LIVES);

   logic [1:0]      raw;
   logic [1:0]      press;
   logic [1:0]      state;
   logic [1:0]      lives;
   logic [3:0]      wave;
   logic            game_start;
   logic [FC_W-1:0] frames;
   logic            disp_press;
   logic            ctr_press;
   logic            final_hit;

   // Bit 0 is the display button, bit 1 the center button.
   assign raw = {bus.button_center, bus.button_display};

   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic                s1;
      logic                s2;
      logic                st;
      logic                st_d;
      logic [DB_WIDTH-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            st   <= 1'b0;
            st_d <= 1'b0;
            cnt  <= '0;
         end else begin
            s1   <= raw[i];
            s2   <= s1;
            st_d <= st;
            if (s2 == st) begin
               cnt <= '0;
            end else if (cnt == DB_LAST) begin
               st  <= s2;
               cnt <= '0;
            end else begin
               cnt <= cnt + DB_ONE;
            end
         end
      end

      assign press[i] = st & ~st_d;
   end

   assign disp_press = press[0];
   assign ctr_press  = press[1];
   assign final_hit  = bus.player_hit && (lives == 2'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_BLACK;
         lives      <= 2'd0;
         wave       <= 4'd0;
         game_start <= 1'b0;
         frames     <= '0;
      end else begin
         game_start <= 1'b0;
         case (state)
            ST_BLACK: begin
               if (disp_press) state <= ST_START;
            end
            ST_START: begin
               if (disp_press || ctr_press) begin
                  state      <= ST_GAME;
                  game_start <= 1'b1;
                  lives      <= LIVES_INIT;
                  wave       <= 4'd0;
               end
            end
            ST_GAME: begin
               // A final hit wins over a display press; a non-final hit still counts alongside it.
               if (final_hit) begin
                  lives  <= 2'd0;
                  state  <= ST_OVER;
                  frames <= '0;
               end else begin
                  if (bus.player_hit && lives > 2'd1) lives <= lives - 2'd1;
                  if (disp_press) state <= ST_BLACK;
               end
               if (bus.aliens_cleared) begin
                  if (wave != 4'd15) wave <= wave + 4'd1;
                  game_start <= ~final_hit;
               end
            end
            ST_OVER: begin
               if (disp_press || (bus.frame_tick && frames == FC_LAST)) begin
                  state <= ST_START;
               end else if (bus.frame_tick) begin
                  frames <= frames + FC_ONE;
               end
            end
         endcase
      end
   end

   assign bus.mode           = state;
   assign bus.objects_frozen = (state != ST_GAME);
   assign bus.game_start     = game_start;
   assign bus.lives          = lives;
   assign bus.wave           = wave;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Randomized and directed bench for game_mode_ctrl against a cycle-level behavioural model.
module tb_game_mode_ctrl;
   localparam int DB = 4;
   localparam int OF = 3;
   localparam int SL = 3;
   localparam logic [9:0] RST_OUT = 10'b00_1_0_00_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   game_mode_ctrl_if bus();

   game_mode_ctrl #(
      .DB_CYCLES(DB), .DB_WIDTH(20), .START_LIVES(SL), .OVER_FRAMES(OF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model: buttons as sample histories with a run-length stability rule,
   // game state as plain integers following the mode rules.
   int m_mode, m_lives, m_wave, m_frames;
   bit m_gs;
   bit m_s1 [2];
   bit m_s2 [2];
   bit m_stable [2];
   bit m_press [2];
   int m_run [2];

   function automatic void model_reset();
      m_mode = 0; m_lives = 0; m_wave = 0; m_frames = 0; m_gs = 0;
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_press[i] = 0; m_run[i] = 0;
      end
   endfunction

   function automatic void model_step(bit raw_d, bit raw_c, bit hit, bit clr, bit ftick);
      bit pd, pc, fin, old;
      bit raw [2];
      pd = m_press[0];
      pc = m_press[1];
      m_gs = 0;
      case (m_mode)
         0: if (pd) m_mode = 1;
         1: if (pd || pc) begin
               m_mode = 2; m_gs = 1; m_lives = SL; m_wave = 0;
            end
         2: begin
               fin = hit && (m_lives == 1);
               if (clr) begin
                  m_wave = (m_wave < 15) ? m_wave + 1 : 15;
                  m_gs = !fin;
               end
               if (fin) begin
                  m_lives = 0; m_mode = 3; m_frames = 0;
               end else begin
                  if (hit && m_lives > 1) m_lives--;
                  if (pd) m_mode = 0;
               end
            end
         default: begin
               if (ftick) m_frames++;
               if (pd || m_frames == OF) m_mode = 1;
            end
      endcase
      raw[0] = raw_d;
      raw[1] = raw_c;
      for (int i = 0; i < 2; i++) begin
         old = m_stable[i];
         if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_stable[i] = m_s2[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_press[i] = m_stable[i] && !old;
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
   endfunction

   function automatic logic [9:0] model_out();
      return {2'(m_mode), (m_mode != 2), m_gs, 2'(m_lives), 4'(m_wave)};
   endfunction

   function automatic logic [9:0] dut_out();
      return {bus.mode, bus.objects_frozen, bus.game_start, bus.lives, bus.wave};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step(bus.button_display, bus.button_center, bus.player_hit,
                      bus.aliens_cleared, bus.frame_tick);
      @(negedge clk);
   endtask

   // Hold a button until the model reaches the target mode, then release and let it settle.
   task automatic press_until(input int btn, input int target, output bit ok);
      ok = 0;
      if (btn == 0) bus.button_display = 1'b1;
      else bus.button_center = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (m_mode == target) begin
            ok = 1;
            break;
         end
      end
      bus.button_display = 1'b0;
      bus.button_center  = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.button_display = 0; bus.button_center = 0;
      bus.frame_tick = 0; bus.player_hit = 0; bus.aliens_cleared = 0;
      model_reset();
      tick();
      tick();
      checks++;
      if (dut_out() !== RST_OUT) begin
         failures++;
         $display("FAIL reset_values: got %h expected %h", dut_out(), RST_OUT);
      end
      rst = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", dut_out(), model_out());
         end
      end
   endtask

   task automatic test_bounce_press();
      int pat [10] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      int changes = 0;
      int chg_cyc = -1;
      bit frozen_all = 1;
      logic [1:0] prev;
      prev = bus.mode;
      for (int i = 0; i < 24; i++) begin
         bus.button_display = (i < 10) ? pat[i][0] : 1'b0;
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL bounce_cycle%0d: got %h expected %h", i, dut_out(), model_out());
         end
         if (bus.mode != prev) begin
            changes++;
            chg_cyc = i;
         end
         if (bus.objects_frozen !== 1'b1) frozen_all = 0;
         prev = bus.mode;
      end
      checks++;
      if (changes != 1 || bus.mode !== 2'd1 || chg_cyc < 6 || chg_cyc > 10) begin
         failures++;
         $display("FAIL bounce_single_press: changes=%0d at %0d mode=%0d, need 1 change in 6..10 to mode 1",
                  changes, chg_cyc, bus.mode);
      end
      checks++;
      if (!frozen_all) begin
         failures++;
         $display("FAIL bounce_frozen: objects_frozen dropped, need 1 throughout");
      end
   endtask

   task automatic test_center_start();
      int gs_cnt = 0;
      bit gs_on_entry = 0;
      bit reached = 0;
      logic [1:0] prev;
      prev = bus.mode;
      bus.button_center = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i == 12) bus.button_center = 1'b0;
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL center_cycle%0d: got %h expected %h", i, dut_out(), model_out());
         end
         if (bus.game_start) gs_cnt++;
         if (bus.mode == 2'd2 && prev != 2'd2) begin
            reached = 1;
            gs_on_entry = bus.game_start;
         end
         prev = bus.mode;
      end
      checks++;
      if (!reached || gs_cnt != 1 || !gs_on_entry) begin
         failures++;
         $display("FAIL center_start: reached=%0d gs_pulses=%0d on_entry=%0d, need 1/1/1",
                  reached, gs_cnt, gs_on_entry);
      end
      checks++;
      if ({bus.mode, bus.lives, bus.wave, bus.objects_frozen} !== {2'd2, 2'd3, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL center_game_state: mode=%0d lives=%0d wave=%0d frozen=%0d, need 2/3/0/0",
                  bus.mode, bus.lives, bus.wave, bus.objects_frozen);
      end
   endtask

   task automatic test_hits_timeout();
      int exp_lives [3] = '{2, 1, 0};
      int exp_mode  [3] = '{2, 2, 3};
      for (int h = 0; h < 3; h++) begin
         bus.player_hit = 1'b1;
         tick();
         bus.player_hit = 1'b0;
         checks++;
         if (bus.lives !== 2'(exp_lives[h]) || bus.mode !== 2'(exp_mode[h])) begin
            failures++;
            $display("FAIL hit%0d: lives=%0d mode=%0d, need %0d/%0d",
                     h, bus.lives, bus.mode, exp_lives[h], exp_mode[h]);
         end
         repeat (4) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
               failures++;
               $display("FAIL hit_gap%0d: got %h expected %h", h, dut_out(), model_out());
            end
         end
      end
      for (int f = 0; f < 3; f++) begin
         bus.frame_tick = 1'b1;
         tick();
         bus.frame_tick = 1'b0;
         checks++;
         if (bus.mode !== ((f < 2) ? 2'd3 : 2'd1) || dut_out() !== model_out()) begin
            failures++;
            $display("FAIL over_tick%0d: got %h mode=%0d, expected %h", f, dut_out(), bus.mode, model_out());
         end
         tick();
      end
   endtask

   task automatic test_waves();
      bit ok;
      int gs_cnt = 0;
      press_until(1, 2, ok);
      checks++;
      if (!ok || bus.mode !== 2'd2) begin
         failures++;
         $display("FAIL waves_enter_game: mode=%0d ok=%0d, need mode 2", bus.mode, ok);
      end
      for (int w = 0; w < 17; w++) begin
         bus.aliens_cleared = 1'b1;
         tick();
         bus.aliens_cleared = 1'b0;
         if (bus.game_start) gs_cnt++;
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL wave%0d: got %h expected %h", w, dut_out(), model_out());
         end
         tick();
      end
      checks++;
      if (gs_cnt != 17 || bus.wave !== 4'd15) begin
         failures++;
         $display("FAIL wave_saturate: gs_pulses=%0d wave=%0d, need 17/15", gs_cnt, bus.wave);
      end
      press_until(0, 0, ok);
      checks++;
      if (!ok || bus.mode !== 2'd0 || bus.wave !== 4'd15 || bus.lives !== 2'd3) begin
         failures++;
         $display("FAIL wave_exit_black: mode=%0d wave=%0d lives=%0d, need 0/15/3",
                  bus.mode, bus.wave, bus.lives);
      end
   endtask

   // Fire a player_hit in exactly the cycle the display press pulse reaches the FSM.
   task automatic test_simultaneous();
      bit ok1, ok2;
      int exp_mode [2] = '{3, 0};
      int exp_lives [2] = '{0, 1};
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            press_until(0, 1, ok1);
         end
         press_until(0, 1, ok1);
         press_until(0, 2, ok2);
         checks++;
         if (!ok1 || !ok2 || dut_out() !== model_out()) begin
            failures++;
            $display("FAIL simul_setup%0d: got %h expected %h", r, dut_out(), model_out());
         end
         repeat (2 - r) begin
            bus.player_hit = 1'b1;
            tick();
            bus.player_hit = 1'b0;
            tick();
         end
         bus.button_display = 1'b1;
         for (int k = 0; k < 20 && !m_press[0]; k++) tick();
         bus.player_hit = 1'b1;
         tick();
         bus.player_hit = 1'b0;
         checks++;
         if (bus.mode !== 2'(exp_mode[r]) || bus.lives !== 2'(exp_lives[r])) begin
            failures++;
            $display("FAIL simul_hit_press%0d: mode=%0d lives=%0d, need %0d/%0d",
                     r, bus.mode, bus.lives, exp_mode[r], exp_lives[r]);
         end
         bus.button_display = 1'b0;
         repeat (8) tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL simul_settle%0d: got %h expected %h", r, dut_out(), model_out());
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      // Reset mid-debounce with the button still held: a fresh press follows.
      bus.button_display = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      checks++;
      if (dut_out() !== RST_OUT) begin
         failures++;
         $display("FAIL rst_debounce_held: got %h expected %h", dut_out(), RST_OUT);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL rst_held_cycle%0d: got %h expected %h", i, dut_out(), model_out());
         end
      end
      checks++;
      if (bus.mode !== 2'd1) begin
         failures++;
         $display("FAIL rst_held_press: mode=%0d, need 1", bus.mode);
      end
      bus.button_display = 1'b0;
      repeat (8) tick();
      // Reset mid-debounce with the button released during reset: no press.
      bus.button_display = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      checks++;
      if (dut_out() !== RST_OUT) begin
         failures++;
         $display("FAIL rst_debounce_rel: got %h expected %h", dut_out(), RST_OUT);
      end
      bus.button_display = 1'b0;
      tick();
      rst = 1'b0;
      repeat (12) tick();
      checks++;
      if (bus.mode !== 2'd0 || dut_out() !== model_out()) begin
         failures++;
         $display("FAIL rst_no_spurious: got %h expected %h", dut_out(), model_out());
      end
      // Reset while in GAME_OVER.
      press_until(0, 1, ok);
      press_until(0, 2, ok);
      repeat (3) begin
         bus.player_hit = 1'b1;
         tick();
         bus.player_hit = 1'b0;
         tick();
      end
      checks++;
      if (bus.mode !== 2'd3 || dut_out() !== model_out()) begin
         failures++;
         $display("FAIL rst_over_setup: got %h expected %h", dut_out(), model_out());
      end
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (dut_out() !== RST_OUT) begin
         failures++;
         $display("FAIL rst_in_over: got %h expected %h", dut_out(), RST_OUT);
      end
      tick();
      rst = 1'b0;
      repeat (6) tick();
      checks++;
      if (dut_out() !== model_out()) begin
         failures++;
         $display("FAIL rst_over_after: got %h expected %h", dut_out(), model_out());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) bus.button_display = ~bus.button_display;
         if ($urandom_range(0, 9) == 0) bus.button_center = ~bus.button_center;
         bus.player_hit     = ($urandom_range(0, 9) == 0);
         bus.aliens_cleared = ($urandom_range(0, 7) == 0);
         bus.frame_tick     = ($urandom_range(0, 3) == 0);
         rst                = ($urandom_range(0, 499) == 0);
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL random_cycle%0d: got %h expected %h", i, dut_out(), model_out());
         end
      end
      rst = 1'b0;
      bus.player_hit = 1'b0;
      bus.aliens_cleared = 1'b0;
      bus.frame_tick = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bounce_press();
      test_center_start();
      test_hits_timeout();
      test_waves();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
